// File: rtl/k6502_alu_ctl.sv
// ============================================================================
// Module   : k6502_alu_ctl
// Purpose  : 6502 core slice: opcode fetch/decode driving the ALU and owning
//            A/X/Y/PC/N/Z. Optional macro K6502_ILLEGAL_NOP_EN turns
//            undefined opcodes into 2-cycle NOPs instead of halting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef OP_INC
`define OP_INC 4'h1
`endif

module k6502_alu_ctl #(
  parameter logic [15:0] RESET_PC = 16'hC000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rdy,
  output logic [15:0] addr,
  output logic        rd,
  input  logic [7:0]  data_in,
  output logic [3:0]  alu_op,
  output logic [1:0]  alu_sel,
  input  logic [7:0]  alu_result,
  output logic [7:0]  reg_a,
  output logic [7:0]  reg_x,
  output logic [7:0]  reg_y,
  output logic [7:0]  operand,
  output logic        flag_n,
  output logic        flag_z,
  output logic        sync,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_HALT   = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [7:0]  r_a, r_x, r_y, r_operand, r_ir;
  logic        r_n, r_z;

  // Bus and ALU controls derive only from registered state, so the ALU's
  // negedge latch always sees settled values.
  always_comb begin
    addr    = r_pc;
    rd      = 1'b0;
    sync    = 1'b0;
    halted  = 1'b0;
    alu_op  = 4'h0;
    alu_sel = 2'b00;
    case (r_state)
      S_FETCH: begin
        rd   = 1'b1;
        sync = 1'b1;
      end
      S_DECODE: begin
        case (r_ir)
          8'hE8: begin
            alu_op  = `OP_INC;
            alu_sel = 2'b01;
          end
          8'hC8: begin
            alu_op  = `OP_INC;
            alu_sel = 2'b10;
          end
          8'hA9, 8'hA2, 8'hA0: rd = 1'b1;
          default: rd = 1'b0;
        endcase
      end
      S_HALT: begin
`ifdef K6502_ILLEGAL_NOP_EN
        halted = 1'b0;
`else
        halted = 1'b1;
`endif
      end
      default: rd = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_a       <= 8'h00;
      r_x       <= 8'h00;
      r_y       <= 8'h00;
      r_operand <= 8'h00;
      r_ir      <= 8'hEA;
      r_n       <= 1'b0;
      r_z       <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (rdy) begin
            r_ir    <= data_in;
            r_pc    <= r_pc + 16'd1;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (r_ir)
            8'hE8: begin
              r_x     <= alu_result;
              r_n     <= alu_result[7];
              r_z     <= (alu_result == 8'h00);
              r_state <= S_FETCH;
            end
            8'hC8: begin
              r_y     <= alu_result;
              r_n     <= alu_result[7];
              r_z     <= (alu_result == 8'h00);
              r_state <= S_FETCH;
            end
            8'hA9, 8'hA2, 8'hA0: begin
              if (rdy) begin
                r_operand <= data_in;
                if (r_ir == 8'hA9) r_a <= data_in;
                if (r_ir == 8'hA2) r_x <= data_in;
                if (r_ir == 8'hA0) r_y <= data_in;
                r_n     <= data_in[7];
                r_z     <= (data_in == 8'h00);
                r_pc    <= r_pc + 16'd1;
                r_state <= S_FETCH;
              end
            end
            8'hEA: r_state <= S_FETCH;
            default: begin
`ifdef K6502_ILLEGAL_NOP_EN
              r_state <= S_FETCH;
`else
              r_state <= S_HALT;
`endif
            end
          endcase
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign reg_a   = r_a;
  assign reg_x   = r_x;
  assign reg_y   = r_y;
  assign operand = r_operand;
  assign flag_n  = r_n;
  assign flag_z  = r_z;

endmodule

`default_nettype wire

// File: tb/tb_k6502_alu_ctl.sv
// ============================================================================
// Module   : tb_k6502_alu_ctl
// Purpose  : Directed bench for k6502_alu_ctl with an instruction-level model
//            checked every cycle, plus literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef OP_INC
`define OP_INC 4'h1
`endif

module tb_k6502_alu_ctl;

  logic        clk = 1'b0;
  logic        reset, rdy;
  logic [15:0] addr, addr2;
  logic        rd, sync, halted, rd2, sync2, halted2;
  logic [7:0]  data_in, alu_result;
  logic [3:0]  alu_op, alu_op2;
  logic [1:0]  alu_sel, alu_sel2;
  logic [7:0]  reg_a, reg_x, reg_y, operand;
  logic [7:0]  reg_a2, reg_x2, reg_y2, operand2;
  logic        flag_n, flag_z, flag_n2, flag_z2;

  logic [7:0]  mem [0:65535];
  logic [3:0]  alu_op_l = 4'h0;
  logic [1:0]  alu_sel_l = 2'b00;
  logic [7:0]  alu_src;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  k6502_alu_ctl #(.RESET_PC(16'hC000)) dut (
    .clk(clk), .reset(reset), .rdy(rdy), .addr(addr), .rd(rd),
    .data_in(data_in), .alu_op(alu_op), .alu_sel(alu_sel),
    .alu_result(alu_result), .reg_a(reg_a), .reg_x(reg_x), .reg_y(reg_y),
    .operand(operand), .flag_n(flag_n), .flag_z(flag_z), .sync(sync),
    .halted(halted)
  );

  // Second instance only exercises the PC wrap on an all-NOP memory.
  k6502_alu_ctl #(.RESET_PC(16'hFFFF)) dut2 (
    .clk(clk), .reset(reset), .rdy(1'b1), .addr(addr2), .rd(rd2),
    .data_in(8'hEA), .alu_op(alu_op2), .alu_sel(alu_sel2),
    .alu_result(8'h00), .reg_a(reg_a2), .reg_x(reg_x2), .reg_y(reg_y2),
    .operand(operand2), .flag_n(flag_n2), .flag_z(flag_z2), .sync(sync2),
    .halted(halted2)
  );

  assign data_in = mem[addr];

  // ALU stand-in: latches op/sel on negedge, result is combinational.
  always @(negedge clk) begin
    alu_op_l  <= alu_op;
    alu_sel_l <= alu_sel;
  end
  always_comb begin
    case (alu_sel_l)
      2'b00:   alu_src = reg_a;
      2'b01:   alu_src = reg_x;
      2'b10:   alu_src = reg_y;
      default: alu_src = operand;
    endcase
    alu_result = (alu_op_l == `OP_INC) ? alu_src + 8'd1 : alu_src;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bit is_ld(input logic [7:0] op);
    return (op == 8'hA9) || (op == 8'hA2) || (op == 8'hA0);
  endfunction

  // Instruction-level model: architectural registers plus where we are in
  // the current instruction (boundary, executing, halted).
  localparam int PH_BND = 0;
  localparam int PH_EXE = 1;
  localparam int PH_HLT = 2;
  int          m_ph = PH_BND;
  bit          m_valid = 1'b0;
  logic [15:0] m_pc;
  logic [7:0]  m_ir, m_a, m_x, m_y, m_op, m_v;
  logic        m_n, m_z;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_a", 16'(reg_a), 16'(m_a));
      chk("cyc_x", 16'(reg_x), 16'(m_x));
      chk("cyc_y", 16'(reg_y), 16'(m_y));
      chk("cyc_operand", 16'(operand), 16'(m_op));
      chk("cyc_nz", 16'({flag_n, flag_z}), 16'({m_n, m_z}));
      case (m_ph)
        PH_BND: begin
          chk("cyc_fetch_addr", addr, m_pc);
          chk("cyc_fetch_ctl", 16'({rd, sync, halted}), 16'(3'b110));
          chk("cyc_fetch_alu", 16'({alu_op, alu_sel}), 16'h0);
        end
        PH_EXE: begin
          chk("cyc_exe_ctl", 16'({rd, sync, halted}), 16'({is_ld(m_ir), 2'b00}));
          chk("cyc_exe_op", 16'(alu_op),
              (m_ir == 8'hE8 || m_ir == 8'hC8) ? 16'(`OP_INC) : 16'h0);
          chk("cyc_exe_sel", 16'(alu_sel),
              (m_ir == 8'hE8) ? 16'd1 : (m_ir == 8'hC8) ? 16'd2 : 16'd0);
          if (is_ld(m_ir)) chk("cyc_exe_addr", addr, m_pc);
        end
        default: chk("cyc_halt_ctl", 16'({rd, sync, halted}), 16'(3'b001));
      endcase
    end

    if (reset) begin
      m_valid = 1'b1;
      m_ph = PH_BND;
      m_pc = 16'hC000;
      m_a = 8'h00; m_x = 8'h00; m_y = 8'h00; m_op = 8'h00; m_ir = 8'hEA;
      m_n = 1'b0; m_z = 1'b0;
    end else if (m_valid) begin
      case (m_ph)
        PH_BND: if (rdy) begin
          m_ir = mem[m_pc];
          m_pc = m_pc + 16'd1;
          m_ph = PH_EXE;
        end
        PH_EXE: begin
          if (m_ir == 8'hE8 || m_ir == 8'hC8) begin
            if (m_ir == 8'hE8) begin m_x = m_x + 8'd1; m_v = m_x; end
            else               begin m_y = m_y + 8'd1; m_v = m_y; end
            m_n = m_v[7]; m_z = (m_v == 8'h00);
            m_ph = PH_BND;
          end else if (is_ld(m_ir)) begin
            if (rdy) begin
              m_v = mem[m_pc];
              m_op = m_v;
              if (m_ir == 8'hA9) m_a = m_v;
              if (m_ir == 8'hA2) m_x = m_v;
              if (m_ir == 8'hA0) m_y = m_v;
              m_n = m_v[7]; m_z = (m_v == 8'h00);
              m_pc = m_pc + 16'd1;
              m_ph = PH_BND;
            end
          end else if (m_ir == 8'hEA) begin
            m_ph = PH_BND;
          end else begin
`ifdef K6502_ILLEGAL_NOP_EN
            m_ph = PH_BND;
`else
            m_ph = PH_HLT;
`endif
          end
        end
        default: m_ph = PH_HLT;
      endcase
    end
  end

  initial begin
    reset = 1'b1;
    rdy   = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'hC000] = 8'hA2; mem[16'hC001] = 8'hFF; mem[16'hC002] = 8'hE8;
    mem[16'hC003] = 8'hA0; mem[16'hC004] = 8'h7F; mem[16'hC005] = 8'hC8;
    mem[16'hC006] = 8'hA9; mem[16'hC007] = 8'h00; mem[16'hC008] = 8'h02;

    step(2);
    reset = 1'b0;
    chk("rst_addr", addr, 16'hC000);
    chk("rst_ctl", 16'({rd, sync, halted}), 16'(3'b110));
    chk("rst_alu", 16'({alu_op, alu_sel}), 16'h0);
    chk("wrap_start", addr2, 16'hFFFF);

    step(1);
    chk("ldx_operand_addr", addr, 16'hC001);
    step(1);
    chk("ldx_x", 16'(reg_x), 16'h00FF);
    chk("ldx_nz", 16'({flag_n, flag_z}), 16'(2'b10));
    chk("wrap_next", addr2, 16'h0000);
    step(1);
    chk("inx_op", 16'(alu_op), 16'(`OP_INC));
    chk("inx_sel", 16'(alu_sel), 16'd1);
    step(1);
    chk("inx_x", 16'(reg_x), 16'h0000);
    chk("inx_nz", 16'({flag_n, flag_z}), 16'(2'b01));
    chk("inx_pc", addr, 16'hC003);

    step(3);
    chk("iny_sel", 16'(alu_sel), 16'd2);
    step(1);
    chk("iny_y", 16'(reg_y), 16'h0080);
    chk("iny_nz", 16'({flag_n, flag_z}), 16'(2'b10));
    chk("iny_pc", addr, 16'hC006);

    step(1);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_addr", addr, 16'hC007);
      chk("stall_nz", 16'({flag_n, flag_z}), 16'(2'b10));
      step(1);
    end
    rdy = 1'b1;
    step(1);
    chk("lda_a", 16'(reg_a), 16'h0000);
    chk("lda_nz", 16'({flag_n, flag_z}), 16'(2'b01));
    chk("lda_5cyc_addr", addr, 16'hC008);
    chk("lda_5cyc_sync", 16'(sync), 16'd1);

    step(2);
`ifdef K6502_ILLEGAL_NOP_EN
    chk("illegal_nop_sync", 16'(sync), 16'd1);
    chk("illegal_nop_addr", addr, 16'hC009);
    step(10);
`else
    for (int i = 0; i < 10; i++) begin
      chk("halt_flag", 16'(halted), 16'd1);
      chk("halt_rd", 16'(rd), 16'd0);
      chk("halt_regs", {reg_x, reg_y}, 16'h0080);
      step(1);
    end
`endif

    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rehalt_addr", addr, 16'hC000);
    chk("rehalt_halted", 16'(halted), 16'd0);

    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("midrst_x", 16'(reg_x), 16'h0000);
    chk("midrst_addr", addr, 16'hC000);
    chk("midrst_sync", 16'(sync), 16'd1);

    step(4);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
